// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, UNROLL bits per CALC cycle,
// sign fix-up in a separate FIX cycle, one-cycle done pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no operation; result holds last value
// CALC   | iterating, UNROLL multiplier bits / divide steps per cycle
// FIX    | sign correction and output word select into result
// DONE   | done pulse; a new start may be accepted back-to-back
module riscv_muldiv #(
   parameter int DATA_W = 32,
   parameter int UNROLL = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              kill,
   input  logic [2:0]        funct3,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam int N_ITER = DATA_W / UNROLL;
   localparam int CW     = $clog2(N_ITER) + 1;

   localparam logic [CW-1:0] CNT_LOAD = CW'(N_ITER);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

   // a_q holds the multiplicand (mul) or the divisor magnitude (div).
   // b_q holds the multiplier being shifted out (mul) or the dividend
   // shifting into the quotient (div). acc_q is the 2W product, or the
   // W+1 bit partial remainder in its low bits for divides.
   logic [1:0]          state_q,    state_d;
   logic [2:0]          funct3_q,   funct3_d;
   logic [DATA_W-1:0]   a_q,        a_d;
   logic [DATA_W-1:0]   b_q,        b_d;
   logic [2*DATA_W-1:0] acc_q,      acc_d;
   logic [CW-1:0]       cnt_q,      cnt_d;
   logic                neg_res_q,  neg_res_d;
   logic                neg_rem_q,  neg_rem_d;
   logic [DATA_W-1:0]   result_q,   result_d;

   logic                accept;
   logic                signed_a;
   logic                signed_b;
   logic                a_neg;
   logic                b_neg;
   logic [DATA_W-1:0]   a_mag;
   logic [DATA_W-1:0]   b_mag;
   logic                div_zero;
   logic                div_ovf;
   logic [DATA_W-1:0]   special_res;

   logic [2*DATA_W-1:0] m_acc;
   logic [DATA_W-1:0]   m_b;
   logic [DATA_W:0]     m_sum;
   logic [DATA_W:0]     d_rem;
   logic [DATA_W-1:0]   d_q;
   logic [DATA_W:0]     d_sh;
   logic [DATA_W:0]     d_diff;
   logic [2*DATA_W-1:0] acc_step;
   logic [DATA_W-1:0]   b_step;

   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quot_fix;
   logic [DATA_W-1:0]   rem_fix;
   logic [DATA_W-1:0]   fix_res;

   // Operand decode at accept: signedness, magnitudes and special divides
   always_comb begin
      accept   = start && !kill && (state_q == S_IDLE || state_q == S_DONE);
      signed_a = 1'b0;
      signed_b = 1'b0;
      case (funct3)
         3'b001, 3'b100, 3'b110: begin
            signed_a = 1'b1;
            signed_b = 1'b1;
         end
         3'b010:  signed_a = 1'b1;
         default: ;
      endcase
      a_neg    = signed_a & op_a[DATA_W-1];
      b_neg    = signed_b & op_b[DATA_W-1];
      a_mag    = a_neg ? -op_a : op_a;
      b_mag    = b_neg ? -op_b : op_b;
      div_zero = funct3[2] && (op_b == '0);
      div_ovf  = funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
      special_res = '0;
      if (div_zero) begin
         special_res = funct3[1] ? op_a : '1;
      end else if (div_ovf) begin
         special_res = funct3[1] ? '0 : op_a;
      end
   end

   // One CALC cycle worth of shift-add and restoring-divide steps
   always_comb begin
      m_acc  = acc_q;
      m_b    = b_q;
      m_sum  = '0;
      d_rem  = acc_q[DATA_W:0];
      d_q    = b_q;
      d_sh   = '0;
      d_diff = '0;
      for (int i = 0; i < UNROLL; i++) begin
         m_sum = {1'b0, m_acc[2*DATA_W-1:DATA_W]} + (m_b[0] ? {1'b0, a_q} : '0);
         m_acc = {m_sum, m_acc[DATA_W-1:1]};
         m_b   = m_b >> 1;

         d_sh   = {d_rem[DATA_W-1:0], d_q[DATA_W-1]};
         d_diff = d_sh - {1'b0, a_q};
         if (!d_diff[DATA_W]) begin
            d_rem = d_diff;
            d_q   = {d_q[DATA_W-2:0], 1'b1};
         end else begin
            d_rem = d_sh;
            d_q   = {d_q[DATA_W-2:0], 1'b0};
         end
      end
      if (funct3_q[2]) begin
         acc_step = {{(DATA_W-1){1'b0}}, d_rem};
         b_step   = d_q;
      end else begin
         acc_step = m_acc;
         b_step   = m_b;
      end
   end

   // Sign correction and output word select for the FIX cycle
   always_comb begin
      prod_fix = neg_res_q ? -acc_q : acc_q;
      quot_fix = neg_res_q ? -b_q : b_q;
      rem_fix  = neg_rem_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
      case (funct3_q)
         3'b000:                 fix_res = prod_fix[DATA_W-1:0];
         3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*DATA_W-1:DATA_W];
         3'b100, 3'b101:         fix_res = quot_fix;
         default:                fix_res = rem_fix;
      endcase
   end

   // Next-state and datapath register update; kill overrides everything
   always_comb begin
      state_d   = state_q;
      funct3_d  = funct3_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      if (kill) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  funct3_d  = funct3;
                  a_d       = funct3[2] ? b_mag : a_mag;
                  b_d       = funct3[2] ? a_mag : b_mag;
                  acc_d     = '0;
                  cnt_d     = CNT_LOAD;
                  neg_res_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  if (div_zero || div_ovf) begin
                     result_d = special_res;
                     state_d  = S_DONE;
                  end else begin
                     state_d  = S_CALC;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_CALC: begin
               acc_d = acc_step;
               b_d   = b_step;
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = S_FIX;
               end
            end
            S_FIX: begin
               result_d = fix_res;
               state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         funct3_q  <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         funct3_q  <= funct3_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

   // Outputs decode straight from registers
   always_comb begin
      busy   = (state_q == S_CALC) || (state_q == S_FIX);
      done   = (state_q == S_DONE);
      result = result_q;
   end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv: directed vector table, random
// operations against an arithmetic reference, and multi-cycle corner cases.
module tb_riscv_muldiv;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        start4;
   logic        kill;
   logic [2:0]  funct3;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy,  done;
   logic        busy4, done4;
   logic [31:0] result, result4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   riscv_muldiv #(.DATA_W(32), .UNROLL(1)) dut (
      .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
   );

   riscv_muldiv #(.DATA_W(32), .UNROLL(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .kill(kill), .funct3(funct3),
      .op_a(op_a), .op_b(op_b), .busy(busy4), .done(done4), .result(result4)
   );

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // RV32M semantics in plain 64-bit / signed arithmetic
   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [63:0] p;
      logic        ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); return p[63:32]; end
         3'd2: begin p = 64'(longint'($signed(a)) * longint'({32'b0, b})); return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
      return 34;
   endfunction

   // Called at #1 after the accept edge (cycle 1); waits for done.
   task automatic wait_done(input int poke_cyc, output logic [31:0] res, output int lat,
                            output int busy_cnt, output logic busy_at_done);
      start        = 1'b0;
      lat          = -1;
      busy_cnt     = 0;
      res          = '0;
      busy_at_done = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         if (done) begin
            res          = result;
            lat          = c;
            busy_at_done = busy;
            break;
         end
         if (busy) busy_cnt++;
         if (c == poke_cyc) begin
            start  = 1'b1;
            funct3 = 3'b101;
            op_a   = 32'd100;
            op_b   = 32'd7;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int poke_cyc, output logic [31:0] res, output int lat,
                        output int busy_cnt, output logic busy_at_done);
      @(negedge clk);
      funct3 = f;
      op_a   = a;
      op_b   = b;
      start  = 1'b1;
      @(posedge clk); #1;
      wait_done(poke_cyc, res, lat, busy_cnt, busy_at_done);
   endtask

   initial begin
      logic [31:0] res, old, ra, rb;
      logic [2:0]  rf;
      logic        bd, saw_done;
      int          lat, bc, el;

      vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
      vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
      vecs[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
      vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34};
      vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
      vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
      vecs[6]  = '{3'b101, 32'd100,        32'd7,         32'd14,        34};
      vecs[7]  = '{3'b111, 32'd100,        32'd7,         32'd2,         34};
      vecs[8]  = '{3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
      vecs[9]  = '{3'b110, 32'd5,          32'd0,         32'd5,         1};
      vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};

      reset = 1'b1; start = 1'b0; start4 = 1'b0; kill = 1'b0;
      funct3 = '0; op_a = '0; op_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset result", result, 32'd0);
      @(negedge clk) reset = 1'b0;

      // Directed table
      for (int i = 0; i < 12; i++) begin
         do_op(vecs[i].f3, vecs[i].a, vecs[i].b, 0, res, lat, bc, bd);
         chk($sformatf("vec%0d result", i), res, vecs[i].exp);
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("vec%0d busy cycles", i), 32'(bc), 32'(vecs[i].lat - 1));
         chk($sformatf("vec%0d busy at done", i), 32'(bd), 32'd0);
      end

      // Random operations against the reference
      for (int i = 0; i < 40; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = $urandom;
         case ($urandom_range(0, 9))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         do_op(rf, ra, rb, 0, res, lat, bc, bd);
         chk($sformatf("rand%0d f%0d %h,%h result", i, rf, ra, rb), res, ref_op(rf, ra, rb));
         chk($sformatf("rand%0d latency", i), 32'(lat), 32'(ref_lat(rf, ra, rb)));
      end

      // Start during busy is ignored
      do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5, res, lat, bc, bd);
      chk("busy-start result", res, 32'hFFFF_FFEB);
      chk("busy-start latency", 32'(lat), 32'd34);

      // Back-to-back: second start sampled in the DONE cycle
      do_op(3'b101, 32'd100, 32'd7, 0, res, lat, bc, bd);
      chk("b2b first result", res, 32'd14);
      funct3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFF_FFFD; start = 1'b1;
      @(posedge clk); #1;
      wait_done(0, res, lat, bc, bd);
      chk("b2b second result", res, 32'hFFFF_FFEB);
      chk("b2b second latency", 32'(lat), 32'd34);

      // Kill in cycle 10 of a DIV
      @(negedge clk);
      old = result;
      funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < 10; c++) begin
         @(posedge clk); #1;
      end
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      chk("kill busy next", 32'(busy), 32'd0);
      chk("kill done next", 32'(done), 32'd0);
      saw_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (done) saw_done = 1'b1;
         @(posedge clk); #1;
      end
      chk("kill no done", 32'(saw_done), 32'd0);
      chk("kill result held", result, old);

      // Reset mid-CALC, then a fresh MUL
      @(negedge clk);
      funct3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midreset busy", 32'(busy), 32'd0);
      chk("midreset done", 32'(done), 32'd0);
      chk("midreset result", result, 32'd0);
      reset = 1'b0;
      do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0, res, lat, bc, bd);
      chk("post-reset mul result", res, 32'hFFFF_FFEB);
      chk("post-reset mul latency", 32'(lat), 32'd34);

      // UNROLL=4 instance
      for (int k = 0; k < 6; k++) begin
         if (k == 0) begin
            rf = 3'b011; ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF;
         end else begin
            rf = 3'($urandom_range(0, 7)); ra = $urandom; rb = $urandom;
         end
         el = (ref_lat(rf, ra, rb) == 1) ? 1 : 10;
         @(negedge clk);
         funct3 = rf; op_a = ra; op_b = rb; start4 = 1'b1;
         @(posedge clk); #1;
         start4 = 1'b0;
         lat = -1; res = '0;
         for (int c = 1; c <= 40; c++) begin
            if (done4) begin
               lat = c;
               res = result4;
               break;
            end
            @(posedge clk); #1;
         end
         chk($sformatf("u4 op%0d f%0d result", k, rf), res, ref_op(rf, ra, rb));
         chk($sformatf("u4 op%0d latency", k), 32'(lat), 32'(el));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/riscv_muldiv.md
# riscv_muldiv

Parametrised iterative multiply/divide unit implementing the RV32M operations for the `riscv` core's execute stage. It accepts one operation per start pulse and computes it over multiple cycles with a radix-2^UNROLL shift-add / restoring-divide datapath. It reports completion with a single-cycle `done` pulse and holds the result until the next accepted start. The pipeline uses `busy` to stall and `kill` to abort on flush.

## Interface
- `DATA_W`, 32: operand/result width. Must be even and ≥ 8.
- `UNROLL`, 1: bits processed per CALC cycle. Must be one of 1, 2 or 4, and must divide `DATA_W`.
- `clk`  in  1: clock. All logic is rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request. Accepted only in IDLE or DONE.
- `kill`  in  1: abort the in-flight operation (pipeline flush).
- `funct3`  in  3: operation select.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  DATA_W: rs1 value (multiplicand or dividend).
- `op_b`  in  DATA_W: rs2 value (multiplier or divisor).
- `busy`  out  1: operation in progress (CALC or FIX).
- `done`  out  1: one-cycle pulse. `result` is valid in this cycle.
- `result`  out  DATA_W: registered result, held stable until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept condition: `start`=1 and `kill`=0 while in IDLE or DONE.
- On accept:
  - Latch `funct3`.
  - Latch operand magnitudes and result-sign flags. Signed operands: MULH a,b; MULHSU a only; DIV/REM a,b.
  - Clear the accumulator and load the iteration counter with `DATA_W/UNROLL`.
- Special divide cases go straight to DONE (skip CALC/FIX):
  - Divisor = 0: DIV/DIVU give all-ones; REM/REMU give `op_a`.
  - Signed overflow (DIV/REM with `op_a`=1<<(DATA_W-1), `op_b`=all-ones): DIV gives `op_a`; REM gives 0.
- CALC, multiply: each cycle consumes UNROLL multiplier bits into a 2·DATA_W product.
- CALC, divide: each cycle performs UNROLL restoring-division steps. The partial remainder is DATA_W+1 bits.
- CALC ends when the counter reaches 0; next state is FIX.
- FIX:
  - Two's-complement negation where needed. Product negated if signs differ. Quotient negated if signs differ. Remainder takes the sign of the dividend.
  - Select the output word: MUL takes the low half; MULH, MULHSU and MULHU take the high half.
  - Register into `result`. Next state is DONE.
- DONE:
  - `done`=1 for exactly one cycle.
  - Next state: CALC if a new start is accepted (or DONE for a special case), otherwise IDLE.
- `busy` = (state==CALC or state==FIX).
- Start while busy: ignored; it has no effect on state or operands.
- `kill`=1 in any state: next state is IDLE, `done` stays 0 and `result` is unchanged.
  - Takes priority over `start` in the same cycle.
  - Takes priority over the FIX-to-DONE transition.
- `reset`=1 (including mid-operation): next state is IDLE; `busy`=0, `done`=0, `result`=0, counter=0.

## Timing
- Start accepted at edge 0:
  - CALC occupies cycles 1..N, where N=`DATA_W/UNROLL`.
  - FIX occupies cycle N+1.
  - DONE occupies cycle N+2.
  - Latency: 34 cycles at defaults; 10 cycles with UNROLL=4.
- Special-case divide: `done` in cycle 1 (latency 1).
- Back-to-back: a start sampled during DONE makes cycle N+3 the first CALC cycle. There is no idle bubble.
- `busy` rises in the cycle after accept and falls in the DONE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Counter width: clog2(DATA_W/UNROLL)+1. It must not wrap.

## Test plan
- MUL 7 × 0xFFFFFFFD → `result`=0xFFFFFFEB.
  - `done` high exactly in cycle 34.
  - `busy` high in cycles 1–33.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Divides with sign handling:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- Special cases, each with `done` in cycle 1:
  - DIV 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- Kill and ignored start:
  - `kill` in cycle 10 of a DIV → IDLE next cycle; no `done` pulse ever; `result` keeps its old value.
  - A start during `busy` is ignored.
  - A start in the DONE cycle runs back-to-back and gives the correct second result.
- Reset and UNROLL=4:
  - `reset` mid-CALC → outputs 0 next cycle; a fresh MUL then completes correctly.
  - With UNROLL=4, MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE with `done` in cycle 10.
